// File: rtl/reg_writeback_queue.sv
`default_nettype none
// ============================================================================
// Module      : reg_writeback_queue
// Description : In-order result queue feeding the register file write port,
//               with per-register pending mask and youngest-match forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_writeback_queue #(
    parameter int N     = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             in_reg,
    input  logic [N-1:0]           in_data,
    input  logic                   drain_en,
    output logic                   reg_write,
    output logic [3:0]             write_register,
    output logic [N-1:0]           write_data,
    output logic [15:0]            pending,
    input  logic [3:0]             fwd_addr,
    output logic                   fwd_hit,
    output logic [N-1:0]           fwd_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

    logic [3:0]      r_reg   [DEPTH];
    logic [N-1:0]    r_data  [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [c_AW-1:0] r_wptr;
    logic [c_AW-1:0] r_rptr;
    logic [c_CW-1:0] r_count;

    logic            w_push;
    logic            w_pop;
    logic            w_nonempty;
    logic [15:0]     w_onehot [DEPTH];
    logic [c_AW-1:0] w_fidx;

    assign w_nonempty = (r_count != '0);
    // Reset gates both handshakes so nothing enters or leaves in a reset cycle.
    assign in_ready   = !rst && (r_count != c_FULL);
    assign reg_write  = !rst && w_nonempty && drain_en;
    assign w_push     = in_valid && in_ready;
    assign w_pop      = reg_write;

    assign write_register = w_nonempty ? r_reg[r_rptr]  : 4'd0;
    assign write_data     = w_nonempty ? r_data[r_rptr] : '0;
    assign count          = r_count;

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        assign w_onehot[g] = r_valid[g] ? (16'd1 << r_reg[g]) : 16'd0;
    end

    always_comb begin
        pending = 16'd0;
        for (int i = 0; i < DEPTH; i++) begin
            pending = pending | w_onehot[i];
        end
    end

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        w_fidx   = r_rptr;
        for (int k = 0; k < DEPTH; k++) begin
            w_fidx = r_rptr + c_AW'(k);
            if (r_valid[w_fidx] && (r_reg[w_fidx] == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = r_data[w_fidx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            if (w_push) begin
                r_reg[r_wptr]   <= in_reg;
                r_valid[r_wptr] <= 1'b1;
                r_wptr          <= r_wptr + c_AW'(1);
            end
            if (w_pop) begin
                r_valid[r_rptr] <= 1'b0;
                r_rptr          <= r_rptr + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Data RAM carries no reset; stale words are masked by r_valid/r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data[r_wptr] <= in_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_writeback_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_writeback_queue
// Description : Self-checking bench: directed vector table, wrap-around burst
//               and randomized traffic against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_writeback_queue;

    localparam int N     = 32;
    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_reg;
    logic [31:0] in_data;
    logic        drain_en;
    logic        reg_write;
    logic [3:0]  write_register;
    logic [31:0] write_data;
    logic [15:0] pending;
    logic [3:0]  fwd_addr;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic [2:0]  count;

    reg_writeback_queue #(.N(N), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_reg(in_reg), .in_data(in_data), .drain_en(drain_en),
        .reg_write(reg_write), .write_register(write_register),
        .write_data(write_data), .pending(pending), .fwd_addr(fwd_addr),
        .fwd_hit(fwd_hit), .fwd_data(fwd_data), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        logic        t_rst;
        logic        t_vld;
        logic [3:0]  t_reg;
        logic [31:0] t_dat;
        logic        t_drn;
        logic [3:0]  t_fa;
        logic        e_ready;
        logic        e_wr;
        logic [3:0]  e_wreg;
        logic [31:0] e_wdata;
        logic [15:0] e_pend;
        logic [2:0]  e_cnt;
        logic        e_hit;
        logic [31:0] e_fd;
    } vec_t;

    vec_t tbl [29];

    typedef struct {
        logic [3:0]  r;
        logic [31:0] d;
    } ent_t;

    ent_t mq [$];
    ent_t pushed [$];
    ent_t written [$];
    bit   rec = 0;
    int   max_cnt = 0;

    // One cycle against the reference queue: outputs are predicted from the
    // stored entries, then the queue is popped/pushed by the handshake rules.
    task automatic cycle(input logic r, input logic v, input logic [3:0] rg,
                         input logic [31:0] d, input logic dr, input logic [3:0] fa);
        logic        e_ready, e_wr, e_hit;
        logic [3:0]  e_wreg;
        logic [31:0] e_wdata, e_fd;
        logic [15:0] e_pend;
        ent_t        e;
        rst = r; in_valid = v; in_reg = rg; in_data = d; drain_en = dr; fwd_addr = fa;
        #2;
        e_ready = !r && (mq.size() < DEPTH);
        e_wr    = !r && (mq.size() > 0) && dr;
        e_wreg  = (mq.size() > 0) ? mq[0].r : 4'd0;
        e_wdata = (mq.size() > 0) ? mq[0].d : 32'd0;
        e_pend  = 16'd0;
        foreach (mq[i]) e_pend[mq[i].r] = 1'b1;
        e_hit = 1'b0;
        e_fd  = 32'd0;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (!e_hit && mq[i].r == fa) begin
                e_hit = 1'b1;
                e_fd  = mq[i].d;
            end
        end
        chk("m_ready", 32'(in_ready), 32'(e_ready));
        chk("m_wr",    32'(reg_write), 32'(e_wr));
        chk("m_wreg",  32'(write_register), 32'(e_wreg));
        chk("m_wdata", write_data, e_wdata);
        chk("m_pend",  32'(pending), 32'(e_pend));
        chk("m_count", 32'(count), 32'(mq.size()));
        chk("m_hit",   32'(fwd_hit), 32'(e_hit));
        chk("m_fdata", fwd_data, e_fd);
        if (rec && reg_write) begin
            e.r = write_register;
            e.d = write_data;
            written.push_back(e);
        end
        if (rec && int'(count) > max_cnt) max_cnt = int'(count);
        @(posedge clk);
        if (r) mq.delete();
        else begin
            if (e_wr) void'(mq.pop_front());
            if (v && e_ready) begin
                e.r = rg;
                e.d = d;
                mq.push_back(e);
                if (rec) pushed.push_back(e);
            end
        end
        #1;
    endtask

    initial begin
        //            rst  vld  reg    data           drn  fa      rdy  wr   wreg   wdata          pend        cnt   hit  fdata
        tbl[0]  = '{1'b1,1'b1,4'd5, 32'hDEADBEEF,1'b1,4'd0,  1'b0,1'b0,4'd0, 32'h0,        16'h0000,3'd0,1'b0,32'h0};
        tbl[1]  = '{1'b0,1'b1,4'd5, 32'hDEADBEEF,1'b1,4'd5,  1'b1,1'b0,4'd0, 32'h0,        16'h0000,3'd0,1'b0,32'h0};
        tbl[2]  = '{1'b0,1'b0,4'd0, 32'h0,       1'b1,4'd5,  1'b1,1'b1,4'd5, 32'hDEADBEEF, 16'h0020,3'd1,1'b1,32'hDEADBEEF};
        tbl[3]  = '{1'b0,1'b0,4'd0, 32'h0,       1'b0,4'd5,  1'b1,1'b0,4'd0, 32'h0,        16'h0000,3'd0,1'b0,32'h0};
        tbl[4]  = '{1'b0,1'b1,4'd1, 32'h11,      1'b0,4'd1,  1'b1,1'b0,4'd0, 32'h0,        16'h0000,3'd0,1'b0,32'h0};
        tbl[5]  = '{1'b0,1'b1,4'd2, 32'h22,      1'b0,4'd1,  1'b1,1'b0,4'd1, 32'h11,       16'h0002,3'd1,1'b1,32'h11};
        tbl[6]  = '{1'b0,1'b1,4'd3, 32'h33,      1'b0,4'd1,  1'b1,1'b0,4'd1, 32'h11,       16'h0006,3'd2,1'b1,32'h11};
        tbl[7]  = '{1'b0,1'b1,4'd4, 32'h44,      1'b0,4'd1,  1'b1,1'b0,4'd1, 32'h11,       16'h000E,3'd3,1'b1,32'h11};
        tbl[8]  = '{1'b0,1'b1,4'd9, 32'h99,      1'b0,4'd4,  1'b0,1'b0,4'd1, 32'h11,       16'h001E,3'd4,1'b1,32'h44};
        tbl[9]  = '{1'b0,1'b0,4'd0, 32'h0,       1'b1,4'd9,  1'b0,1'b1,4'd1, 32'h11,       16'h001E,3'd4,1'b0,32'h0};
        tbl[10] = '{1'b0,1'b0,4'd0, 32'h0,       1'b1,4'd1,  1'b1,1'b1,4'd2, 32'h22,       16'h001C,3'd3,1'b0,32'h0};
        tbl[11] = '{1'b0,1'b0,4'd0, 32'h0,       1'b1,4'd3,  1'b1,1'b1,4'd3, 32'h33,       16'h0018,3'd2,1'b1,32'h33};
        tbl[12] = '{1'b0,1'b0,4'd0, 32'h0,       1'b1,4'd3,  1'b1,1'b1,4'd4, 32'h44,       16'h0010,3'd1,1'b0,32'h0};
        tbl[13] = '{1'b0,1'b0,4'd0, 32'h0,       1'b1,4'd0,  1'b1,1'b0,4'd0, 32'h0,        16'h0000,3'd0,1'b0,32'h0};
        tbl[14] = '{1'b0,1'b1,4'd7, 32'hA,       1'b0,4'd7,  1'b1,1'b0,4'd0, 32'h0,        16'h0000,3'd0,1'b0,32'h0};
        tbl[15] = '{1'b0,1'b1,4'd7, 32'hB,       1'b0,4'd7,  1'b1,1'b0,4'd7, 32'hA,        16'h0080,3'd1,1'b1,32'hA};
        tbl[16] = '{1'b0,1'b1,4'd3, 32'hC,       1'b0,4'd7,  1'b1,1'b0,4'd7, 32'hA,        16'h0080,3'd2,1'b1,32'hB};
        tbl[17] = '{1'b0,1'b0,4'd0, 32'h0,       1'b0,4'd7,  1'b1,1'b0,4'd7, 32'hA,        16'h0088,3'd3,1'b1,32'hB};
        tbl[18] = '{1'b0,1'b0,4'd0, 32'h0,       1'b0,4'd2,  1'b1,1'b0,4'd7, 32'hA,        16'h0088,3'd3,1'b0,32'h0};
        tbl[19] = '{1'b0,1'b0,4'd0, 32'h0,       1'b0,4'd3,  1'b1,1'b0,4'd7, 32'hA,        16'h0088,3'd3,1'b1,32'hC};
        tbl[20] = '{1'b1,1'b0,4'd0, 32'h0,       1'b0,4'd3,  1'b0,1'b0,4'd7, 32'hA,        16'h0088,3'd3,1'b1,32'hC};
        tbl[21] = '{1'b0,1'b0,4'd0, 32'h0,       1'b1,4'd7,  1'b1,1'b0,4'd0, 32'h0,        16'h0000,3'd0,1'b0,32'h0};
        tbl[22] = '{1'b0,1'b0,4'd0, 32'h0,       1'b1,4'd3,  1'b1,1'b0,4'd0, 32'h0,        16'h0000,3'd0,1'b0,32'h0};
        tbl[23] = '{1'b0,1'b1,4'd0, 32'h100,     1'b0,4'd0,  1'b1,1'b0,4'd0, 32'h0,        16'h0000,3'd0,1'b0,32'h0};
        tbl[24] = '{1'b0,1'b1,4'd15,32'h200,     1'b0,4'd0,  1'b1,1'b0,4'd0, 32'h100,      16'h0001,3'd1,1'b1,32'h100};
        tbl[25] = '{1'b0,1'b1,4'd0, 32'h300,     1'b0,4'd0,  1'b1,1'b0,4'd0, 32'h100,      16'h8001,3'd2,1'b1,32'h100};
        tbl[26] = '{1'b0,1'b1,4'd8, 32'h400,     1'b0,4'd0,  1'b1,1'b0,4'd0, 32'h100,      16'h8001,3'd3,1'b1,32'h300};
        tbl[27] = '{1'b0,1'b1,4'd6, 32'h600,     1'b1,4'd0,  1'b0,1'b1,4'd0, 32'h100,      16'h8101,3'd4,1'b1,32'h300};
        tbl[28] = '{1'b0,1'b0,4'd0, 32'h0,       1'b0,4'd6,  1'b1,1'b0,4'd15,32'h200,      16'h8101,3'd3,1'b0,32'h0};

        rst = 1'b1; in_valid = 1'b0; in_reg = 4'd0; in_data = 32'd0;
        drain_en = 1'b0; fwd_addr = 4'd0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 29; i++) begin
            rst = tbl[i].t_rst; in_valid = tbl[i].t_vld; in_reg = tbl[i].t_reg;
            in_data = tbl[i].t_dat; drain_en = tbl[i].t_drn; fwd_addr = tbl[i].t_fa;
            #2;
            chk($sformatf("v%0d_ready", i), 32'(in_ready),       32'(tbl[i].e_ready));
            chk($sformatf("v%0d_wr", i),    32'(reg_write),      32'(tbl[i].e_wr));
            chk($sformatf("v%0d_wreg", i),  32'(write_register), 32'(tbl[i].e_wreg));
            chk($sformatf("v%0d_wdata", i), write_data,          tbl[i].e_wdata);
            chk($sformatf("v%0d_pend", i),  32'(pending),        32'(tbl[i].e_pend));
            chk($sformatf("v%0d_count", i), 32'(count),          32'(tbl[i].e_cnt));
            chk($sformatf("v%0d_hit", i),   32'(fwd_hit),        32'(tbl[i].e_hit));
            chk($sformatf("v%0d_fdata", i), fwd_data,            tbl[i].e_fd);
            @(posedge clk);
            #1;
        end

        // Model starts empty from here, so discard the table's leftovers.
        rst = 1'b1; in_valid = 1'b0; drain_en = 1'b0;
        @(posedge clk);
        #1;
        mq.delete();

        // Back-to-back pushes with draining: five trips round a 4-entry ring.
        rec = 1;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b1, 4'($urandom_range(0, 15)), $urandom, 1'b1, 4'($urandom_range(0, 15)));
        end
        cycle(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd0);
        cycle(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd0);
        rec = 0;
        chk("burst_max_count", 32'(max_cnt), 32'd1);
        chk("burst_write_cnt", 32'(written.size()), 32'd20);
        for (int i = 0; i < 20 && i < written.size(); i++) begin
            chk($sformatf("burst_order_%0d", i), {24'd0, written[i].r, 4'd0} ^ written[i].d,
                {24'd0, pushed[i].r, 4'd0} ^ pushed[i].d);
        end

        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7),
                  4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 1) == 1,
                  4'($urandom_range(0, 15)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_writeback_queue.md
# reg_writeback_queue

Write-side initiator for the 16-entry register file. Execution units push (register, data) results through a valid/ready handshake. The block buffers them in order in a DEPTH-entry FIFO and drives the register file write port (reg_write, write_register, write_data) with at most one write per cycle. It also exports a per-register pending mask and a youngest-match forwarding lookup, so decode can stall on, or bypass, results not yet committed to the register file.

## Interface
- N, 32, data width; must match the register file N.
- DEPTH, 4, FIFO entries; a power of two, ≥ 2.

- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  producer has a result.
- in_ready  out  1  queue can accept; equals (count < DEPTH).
- in_reg  in  4  destination register index.
- in_data  in  N  result value.
- drain_en  in  1  register file write port is available this cycle.
- reg_write  out  1  write strobe to the register file.
- write_register  out  4  write index to the register file.
- write_data  out  N  write data to the register file.
- pending  out  16  bit r is 1 while any stored entry targets register r.
- fwd_addr  in  4  forwarding lookup index.
- fwd_hit  out  1  a stored entry targets fwd_addr.
- fwd_data  out  N  data of the youngest stored entry targeting fwd_addr; 0 when there is no hit.
- count  out  $clog2(DEPTH)+1  number of stored entries.

## Operation
- **Storage.** Circular buffer of {reg[3:0], data[N-1:0]} entries, with a write pointer, a read pointer and count. Pointers wrap modulo DEPTH.
- **Push.** A push occurs when in_valid && in_ready at posedge. The entry is stored at the write pointer, and the write pointer and count are incremented.
- **Pop.** A pop occurs when reg_write is 1 at posedge, i.e. when count ≠ 0 && drain_en. The read pointer is incremented and count is decremented.
- **Simultaneous push and pop.**
  - Both may occur in the same cycle; count is then unchanged.
  - When full, in_ready is 0 even if a pop occurs in the same cycle. There is no full-bypass.
- **Write port outputs.** Driven combinationally from the head entry and drain_en:
  - reg_write = (count ≠ 0) && drain_en.
  - write_register and write_data equal the head entry when count ≠ 0, else 0.
- **Ordering.** Entries commit strictly in push order. Multiple entries for the same register are legal; the last pushed value is the final register file content.
- **pending.** Combinational OR over the valid entries of a one-hot decode of each entry's reg.
  - An entry being popped this cycle still counts as pending in that cycle.
  - A push is not reflected until after its posedge.
- **Forwarding.**
  - fwd_hit / fwd_data search the valid entries from youngest (write pointer − 1) to oldest; the first match wins.
  - Incoming in_data is not forwarded in its push cycle.
- **Reset.** While rst is high at posedge:
  - count, both pointers and all entry valid state are cleared.
  - Queued results are discarded and never written.
  - During a reset cycle, in_ready = 0 and reg_write = 0.
  - After reset: count = 0, pending = 0, fwd_hit = 0, fwd_data = 0, write_register = 0, write_data = 0, in_ready = 1.
  - Entry data RAM contents need not be cleared.
- **Register 0** has no special treatment; it is queued and written like any other index.

## Timing
- **Push-to-write latency.** A result pushed at posedge k is visible on the write port in cycle k+1 if the queue was empty and drain_en = 1. The register file captures it on the negedge inside cycle k+1, and it is popped at posedge k+1.
- **Output stability.** Write port outputs are stable from posedge through the following negedge; they depend only on flops and drain_en. drain_en must be stable before negedge.
- **Throughput.** One push and one pop per cycle sustained.
- **Full queue.** With count = DEPTH and drain_en = 0, in_ready stays 0 indefinitely and no entry is lost or overwritten.
- **Empty queue.** With count = 0, no write is issued regardless of drain_en.
- **Wrap-around.** Pointer wrap from DEPTH−1 to 0 must not corrupt ordering, pending or forwarding.
- **Reset mid-burst.** Reset asserted with entries queued: no reg_write in the reset cycle or any following cycle until new pushes arrive.

## Test plan
- **Reset and single write.** Reset, then push (r5, 0xDEADBEEF) with drain_en = 1.
  - In the next cycle: reg_write = 1, write_register = 5, write_data = 0xDEADBEEF, pending[5] = 1.
  - In the cycle after that: count = 0 and pending = 0.
- **Fill to full.** With drain_en = 0, push r1..r4 with data 0x11..0x44.
  - After 4 pushes: count = 4, in_ready = 0, pending = 0x001E.
  - A fifth push is refused.
  - Then raise drain_en: writes r1, r2, r3, r4 in four consecutive cycles, then reg_write = 0.
- **Forwarding, youngest wins.** With drain_en = 0, push (r7, 0xA), (r7, 0xB), (r3, 0xC).
  - fwd_addr = 7 → fwd_hit = 1, fwd_data = 0xB.
  - fwd_addr = 2 → fwd_hit = 0, fwd_data = 0.
- **Concurrent push/pop with wrap-around.** Run 20 back-to-back pushes with drain_en = 1 and random registers and data.
  - count never exceeds 1.
  - The write sequence matches the push order exactly.
  - Pointers wrap at least 4 times.
- **Reset mid-operation.** Hold 3 entries with drain_en = 0, pulse rst for one cycle, then raise drain_en.
  - No reg_write is issued.
  - count = 0 and pending = 0.
  - in_ready = 1 after the reset cycle.
- **Full with simultaneous pop.** count = DEPTH and drain_en = 1 with in_valid = 1.
  - In that cycle: in_ready = 0, no push occurs, and one pop occurs.
  - In the next cycle: count = DEPTH−1 and in_ready = 1.
